arty_boot_ctrl: RTL

Board-level boot and run controller for the Arty PULPino build. It sits between the raw board inputs (MMCM `locked`, fetch-enable switch, soft-reset button) and the PULPino SoC. It sequences SoC reset release after the clock is stable and gates `fetch_enable` so that it is only asserted to a running SoC. It also debounces the mechanical inputs and exposes its state for the LEDs.

---
 rtl/arty_boot_pkg.sv | 21 ++
 rtl/arty_debounce.sv | 31 +++
 rtl/arty_boot_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/arty_boot_pkg.sv
// Shared types and encodings for the Arty PULPino boot/run controller.
package arty_boot_pkg;

    localparam int unsigned STATE_W = 2;

    // state_o encodings, also used by the LED decode
    localparam logic [STATE_W-1:0] ENC_WAIT_LOCK = 2'd0;
    localparam logic [STATE_W-1:0] ENC_HOLD_RST  = 2'd1;
    localparam logic [STATE_W-1:0] ENC_IDLE      = 2'd2;
    localparam logic [STATE_W-1:0] ENC_RUN       = 2'd3;

    typedef enum logic [STATE_W-1:0] {
        WAIT_LOCK = ENC_WAIT_LOCK,
        HOLD_RST  = ENC_HOLD_RST,
        IDLE      = ENC_IDLE,
        RUN       = ENC_RUN
    } state_t;

    localparam int unsigned SOFT_CNT_W = 8;

endpackage

// File: rtl/arty_debounce.sv
// Debouncer: output follows an already-synchronized input only after it has
// differed from the output for CYCLES consecutive cycles.
module arty_debounce #(
    parameter int unsigned CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    localparam int unsigned CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic [CNT_W-1:0] cnt;

    // Count consecutive disagreeing cycles; any agreement restarts the count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            q_o <= 1'b0;
        end else if (d_i == q_o) begin
            cnt <= '0;
        end else if (cnt == CNT_W'(CYCLES - 1)) begin
            cnt <= '0;
            q_o <= d_i;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/arty_boot_ctrl.sv
// Board boot/run controller: sequences SoC reset after MMCM lock, gates
// fetch enable to a running SoC, debounces switch and soft-reset button.
module arty_boot_ctrl
    import arty_boot_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES  = 50000,
    parameter int unsigned LOCK_WAIT_CYCLES = 1024,
    parameter int unsigned RST_HOLD_CYCLES  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pll_locked_i,
    input  logic                  fetch_sw_i,
    input  logic                  soft_rst_btn_i,
    output logic                  soc_rst_no,
    output logic                  fetch_enable_o,
    output logic [STATE_W-1:0]    state_o,
    output logic [SOFT_CNT_W-1:0] soft_rst_cnt_o
);

    localparam int unsigned LOCK_W = (LOCK_WAIT_CYCLES > 1) ? $clog2(LOCK_WAIT_CYCLES) : 1;
    localparam int unsigned HOLD_W = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;

    if (DEBOUNCE_CYCLES < 2 || LOCK_WAIT_CYCLES < 2 || RST_HOLD_CYCLES < 2) begin : g_param_check
        $error("arty_boot_ctrl: all cycle parameters must be >= 2");
    end

    logic [1:0] lock_sync;
    logic [1:0] sw_sync;
    logic [1:0] btn_sync;
    logic       lock_s;
    logic       fetch_db;
    logic       btn_db;
    logic       btn_db_q;
    logic       btn_rise;

    state_t                state;
    state_t                state_next;
    logic [LOCK_W-1:0]     lock_cnt;
    logic [LOCK_W-1:0]     lock_cnt_next;
    logic [HOLD_W-1:0]     hold_cnt;
    logic [HOLD_W-1:0]     hold_cnt_next;
    logic [SOFT_CNT_W-1:0] soft_cnt_next;
    logic                  soc_rst_n_next;
    logic                  fetch_en_next;

    // Two-flop synchronizers for the raw board inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_sync <= '0;
            sw_sync   <= '0;
            btn_sync  <= '0;
        end else begin
            lock_sync <= {lock_sync[0], pll_locked_i};
            sw_sync   <= {sw_sync[0], fetch_sw_i};
            btn_sync  <= {btn_sync[0], soft_rst_btn_i};
        end
    end

    assign lock_s = lock_sync[1];

    arty_debounce #(
        .CYCLES (DEBOUNCE_CYCLES)
    ) u_db_fetch (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (sw_sync[1]),
        .q_o   (fetch_db)
    );

    arty_debounce #(
        .CYCLES (DEBOUNCE_CYCLES)
    ) u_db_btn (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (btn_sync[1]),
        .q_o   (btn_db)
    );

    // Delayed debounced button for rising-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_db_q <= 1'b0;
        end else begin
            btn_db_q <= btn_db;
        end
    end

    assign btn_rise = btn_db & ~btn_db_q;

    // State, counters and outputs registered from the next-state decode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= WAIT_LOCK;
            lock_cnt       <= '0;
            hold_cnt       <= '0;
            soft_rst_cnt_o <= '0;
            soc_rst_no     <= 1'b0;
            fetch_enable_o <= 1'b0;
        end else begin
            state          <= state_next;
            lock_cnt       <= lock_cnt_next;
            hold_cnt       <= hold_cnt_next;
            soft_rst_cnt_o <= soft_cnt_next;
            soc_rst_no     <= soc_rst_n_next;
            fetch_enable_o <= fetch_en_next;
        end
    end

    // Next-state: lock loss beats soft reset beats per-state transitions
    always_comb begin
        state_next    = state;
        lock_cnt_next = lock_cnt;
        hold_cnt_next = hold_cnt;
        soft_cnt_next = soft_rst_cnt_o;

        if (state != WAIT_LOCK && !lock_s) begin
            state_next    = WAIT_LOCK;
            lock_cnt_next = '0;
        end else if (state != WAIT_LOCK && btn_rise) begin
            state_next    = HOLD_RST;
            hold_cnt_next = '0;
            if (soft_rst_cnt_o != '1) begin
                soft_cnt_next = soft_rst_cnt_o + SOFT_CNT_W'(1);
            end
        end else begin
            case (state)
                WAIT_LOCK: begin
                    if (!lock_s) begin
                        lock_cnt_next = '0;
                    end else if (lock_cnt == LOCK_W'(LOCK_WAIT_CYCLES - 1)) begin
                        state_next    = HOLD_RST;
                        hold_cnt_next = '0;
                    end else begin
                        lock_cnt_next = lock_cnt + LOCK_W'(1);
                    end
                end
                HOLD_RST: begin
                    if (hold_cnt == HOLD_W'(RST_HOLD_CYCLES - 1)) begin
                        state_next = IDLE;
                    end else begin
                        hold_cnt_next = hold_cnt + HOLD_W'(1);
                    end
                end
                IDLE: begin
                    if (fetch_db) begin
                        state_next = RUN;
                    end
                end
                RUN: begin
                    if (!fetch_db) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next    = WAIT_LOCK;
                    lock_cnt_next = '0;
                end
            endcase
        end

        soc_rst_n_next = (state_next == IDLE) || (state_next == RUN);
        fetch_en_next  = (state_next == RUN);
    end

    assign state_o = state;

endmodule
